// File: rtl/tconv_ctrl_gen.sv
// Sequencer for the transposed-convolution engine: weight load, IFM row sweep,
// line-buffer read enables and their PIPE_LAT-delayed write enables.
module tconv_ctrl_gen #(
    parameter int K        = 4,
    parameter int IFM      = 9,
    parameter int STRIDE   = 2,
    parameter int CI       = 3,
    parameter int CO       = 4,
    parameter int PIPE_LAT = 1
) (
    input  logic                                 clk1,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 stall,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 wgt_rd,
    output logic [$clog2(K*K)-1:0]               wgt_idx,
    output logic [K*K-1:0]                       set_wgt,
    output logic                                 ifm_rd,
    output logic [$clog2(IFM)-1:0]               ifm_row,
    output logic [$clog2(IFM+K)-1:0]             ifm_col,
    output logic [K-1:0]                         rd_en,
    output logic [K-1:0]                         wr_en,
    output logic                                 acc_clr,
    output logic                                 psum_rd,
    output logic                                 out_valid,
    output logic [((CI > 1) ? $clog2(CI) : 1)-1:0] ch_idx,
    output logic [((CO > 1) ? $clog2(CO) : 1)-1:0] flt_idx
);

    localparam int NW    = K * K;
    localparam int WI_W  = $clog2(NW);
    localparam int ROW_W = $clog2(IFM);
    localparam int COL_W = $clog2(IFM + K);
    localparam int CH_W  = (CI > 1) ? $clog2(CI) : 1;
    localparam int FLT_W = (CO > 1) ? $clog2(CO) : 1;
    localparam int DR_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [WI_W-1:0]  WGT_LAST = WI_W'(NW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IFM - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM + K - 2);
    localparam logic [COL_W-1:0] COL_IFM  = COL_W'(IFM);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CI - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(CO - 1);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LAT - 1);

    // STRIDE only matters to the downstream address generator.
    if (STRIDE < 1 || K < 2 || PIPE_LAT < 1) begin : g_bad_cfg
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_WGT, S_COMPUTE, S_END_ROW, S_END_CHANNEL, S_END_FILTER, S_DRAIN
    } state_t;

    state_t           state;
    logic             ready;
    logic [DR_W-1:0]  drain_cnt;
    logic             act_ld;
    logic             act_cp;
    logic             ov_now;
    logic [K:0]       dly [PIPE_LAT];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wgt_idx   <= '0;
            ifm_row   <= '0;
            ifm_col   <= '0;
            ch_idx    <= '0;
            flt_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            // A start seen on the first edge after reset release is dropped.
            ready <= 1'b1;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        state <= S_LOAD_WGT;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD_WGT: begin
                    if (!stall) begin
                        if (wgt_idx == WGT_LAST) begin
                            wgt_idx <= '0;
                            state   <= S_COMPUTE;
                        end else begin
                            wgt_idx <= wgt_idx + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!stall) begin
                        if (ifm_col == COL_LAST) begin
                            ifm_col <= '0;
                            if (ifm_row != ROW_LAST) begin
                                state <= S_END_ROW;
                            end else begin
                                ifm_row <= '0;
                                state   <= (ch_idx != CH_LAST) ? S_END_CHANNEL : S_END_FILTER;
                            end
                        end else begin
                            ifm_col <= ifm_col + 1'b1;
                        end
                    end
                end
                S_END_ROW: begin
                    ifm_row <= ifm_row + 1'b1;
                    state   <= S_COMPUTE;
                end
                S_END_CHANNEL: begin
                    ch_idx <= ch_idx + 1'b1;
                    state  <= S_LOAD_WGT;
                end
                S_END_FILTER: begin
                    ch_idx <= '0;
                    if (flt_idx != FLT_LAST) begin
                        flt_idx <= flt_idx + 1'b1;
                        state   <= S_LOAD_WGT;
                    end else begin
                        flt_idx   <= '0;
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DR_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall gates the fetch/read strobes in the same cycle; counters hold above.
    always_comb begin
        act_ld  = (state == S_LOAD_WGT) && !stall;
        act_cp  = (state == S_COMPUTE) && !stall;
        wgt_rd  = act_ld;
        set_wgt = act_ld ? ({{(NW-1){1'b0}}, 1'b1} << wgt_idx) : '0;
        ifm_rd  = act_cp && (ifm_col < COL_IFM);
        rd_en   = {K{act_cp}};
        acc_clr = act_cp && (ch_idx == '0) && (ifm_row == '0) && (ifm_col == '0);
        psum_rd = rd_en[0] && (ch_idx != '0);
        ov_now  = rd_en[0] && (ch_idx == CH_LAST);
    end

    // Write-enable delay line carries the last-channel flag alongside; never stalls.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {ov_now, rd_en};
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign wr_en     = dly[PIPE_LAT-1][K-1:0];
    assign out_valid = dly[PIPE_LAT-1][K];

endmodule

// File: tb/tb_tconv_ctrl_gen.sv
// Bench for tconv_ctrl_gen: default config against a step-list model with random stall,
// plus a small K=3/IFM=5/PIPE_LAT=3 instance checked by event counts.
module tb_tconv_ctrl_gen;

    localparam int K = 4, IFM = 9, CI = 3, CO = 4, PL = 1;
    localparam int NW = K * K, COLS = IFM + K - 1;
    localparam int WI_W = $clog2(NW), ROW_W = $clog2(IFM), COL_W = $clog2(IFM + K);
    localparam int CH_W = $clog2(CI), FLT_W = $clog2(CO);
    localparam int RUN_BUSY = CI * CO * (NW + IFM * COLS + IFM) + PL;

    logic clk1 = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, start2 = 1'b0;

    logic             busy, done, wgt_rd, ifm_rd, acc_clr, psum_rd, out_valid;
    logic [WI_W-1:0]  wgt_idx;
    logic [NW-1:0]    set_wgt;
    logic [ROW_W-1:0] ifm_row;
    logic [COL_W-1:0] ifm_col;
    logic [K-1:0]     rd_en, wr_en;
    logic [CH_W-1:0]  ch_idx;
    logic [FLT_W-1:0] flt_idx;

    logic       busy2, done2, wgt_rd2, ifm_rd2, acc_clr2, psum_rd2, out_valid2;
    logic [3:0] wgt_idx2;
    logic [8:0] set_wgt2;
    logic [2:0] ifm_row2, ifm_col2, rd_en2, wr_en2;
    logic       ch_idx2, flt_idx2;

    tconv_ctrl_gen #(.K(K), .IFM(IFM), .STRIDE(2), .CI(CI), .CO(CO), .PIPE_LAT(PL)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .stall(stall), .busy(busy), .done(done),
        .wgt_rd(wgt_rd), .wgt_idx(wgt_idx), .set_wgt(set_wgt), .ifm_rd(ifm_rd),
        .ifm_row(ifm_row), .ifm_col(ifm_col), .rd_en(rd_en), .wr_en(wr_en),
        .acc_clr(acc_clr), .psum_rd(psum_rd), .out_valid(out_valid),
        .ch_idx(ch_idx), .flt_idx(flt_idx));

    tconv_ctrl_gen #(.K(3), .IFM(5), .STRIDE(2), .CI(1), .CO(1), .PIPE_LAT(3)) dut_s (
        .clk1(clk1), .rst_n(rst_n), .start(start2), .stall(1'b0), .busy(busy2), .done(done2),
        .wgt_rd(wgt_rd2), .wgt_idx(wgt_idx2), .set_wgt(set_wgt2), .ifm_rd(ifm_rd2),
        .ifm_row(ifm_row2), .ifm_col(ifm_col2), .rd_en(rd_en2), .wr_en(wr_en2),
        .acc_clr(acc_clr2), .psum_rd(psum_rd2), .out_valid(out_valid2),
        .ch_idx(ch_idx2), .flt_idx(flt_idx2));

    always #5 clk1 = ~clk1;

    int n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one entry per expected non-stalled cycle of a run.
    // kind 0 = weight load, 1 = compute step, 2 = bookkeeping cycle, 3 = idle/done.
    typedef struct {
        int kind; int busy; int done; int widx; int row; int col; int ch; int flt;
    } step_t;

    step_t      steps[$];
    logic [K:0] hist[$];
    logic [2:0] hist2[$];
    bit         ready = 0;
    int         n_busy, n_done, n_ifm, n_wgt, n_stall;
    int         n2_busy, n2_done, n2_wgt, n2_acc, n2_psum, n2_ov, k2;

    function automatic step_t mk(int kind, int widx, int row, int col, int ch, int flt);
        step_t s;
        s.kind = kind; s.busy = (kind == 3) ? 0 : 1; s.done = 0;
        s.widx = widx; s.row = row; s.col = col; s.ch = ch; s.flt = flt;
        return s;
    endfunction

    function automatic void build_run();
        step_t d;
        for (int f = 0; f < CO; f++)
            for (int c = 0; c < CI; c++) begin
                for (int w = 0; w < NW; w++) steps.push_back(mk(0, w, 0, 0, c, f));
                for (int r = 0; r < IFM; r++) begin
                    for (int col = 0; col < COLS; col++) steps.push_back(mk(1, 0, r, col, c, f));
                    if (r < IFM - 1) steps.push_back(mk(2, 0, r, 0, c, f));
                end
                steps.push_back(mk(2, 0, 0, 0, c, f));
            end
        for (int i = 0; i < PL; i++) steps.push_back(mk(2, 0, 0, 0, 0, 0));
        d = mk(3, 0, 0, 0, 0, 0);
        d.done = 1;
        steps.push_back(d);
    endfunction

    always @(negedge clk1) begin
        step_t      cur;
        bit         st, e_cp, e_ld;
        logic [K:0] e_wr;
        logic [NW-1:0] e_set;
        if (!rst_n) begin
            check("reset", 64'({busy, done, wgt_rd, wgt_idx, set_wgt, ifm_rd, ifm_row, ifm_col,
                  rd_en, wr_en, acc_clr, psum_rd, out_valid, ch_idx, flt_idx}), 64'd0);
            steps.delete();
            hist.delete();
            for (int i = 0; i < PL; i++) hist.push_back('0);
            ready = 0;
        end else begin
            cur  = (steps.size() > 0) ? steps[0] : mk(3, 0, 0, 0, 0, 0);
            st   = (cur.kind <= 1) && stall;
            e_ld = (cur.kind == 0) && !st;
            e_cp = (cur.kind == 1) && !st;
            e_set = e_ld ? (NW'(1) << cur.widx) : '0;
            check("ctl", 64'({busy, done}), 64'({cur.busy[0], cur.done[0]}));
            check("idx", 64'({wgt_idx, ifm_row, ifm_col, ch_idx, flt_idx}),
                  64'({WI_W'(cur.widx), ROW_W'(cur.row), COL_W'(cur.col), CH_W'(cur.ch), FLT_W'(cur.flt)}));
            check("strobe", 64'({wgt_rd, set_wgt, ifm_rd, rd_en, acc_clr, psum_rd}),
                  64'({e_ld, e_set, e_cp && (cur.col < IFM), {K{e_cp}},
                       e_cp && cur.ch == 0 && cur.row == 0 && cur.col == 0, e_cp && cur.ch != 0}));
            e_wr = hist.pop_front();
            hist.push_back({e_cp && cur.ch == CI - 1, {K{e_cp}}});
            check("wr_en", 64'({out_valid, wr_en}), 64'(e_wr));
            n_busy += busy; n_done += done; n_ifm += ifm_rd; n_wgt += wgt_rd; n_stall += st;
            if (!st && steps.size() > 0) void'(steps.pop_front());
            if (cur.kind == 3 && start && ready) build_run();
            ready = 1;
        end
    end

    always @(negedge clk1) begin
        logic [2:0] e2;
        if (!rst_n) begin
            hist2.delete();
            for (int i = 0; i < 3; i++) hist2.push_back('0);
            k2 = 0;
        end else begin
            e2 = hist2.pop_front();
            hist2.push_back(rd_en2);
            check("s_wr_dly", 64'(wr_en2), 64'(e2));
            check("s_ov", 64'(out_valid2), 64'(e2[0]));
            if (wgt_rd2) begin
                check("s_set_wgt", 64'(set_wgt2), 64'(9'(1) << k2));
                k2++;
            end
            n2_busy += busy2; n2_done += done2; n2_wgt += wgt_rd2;
            n2_acc += acc_clr2; n2_psum += psum_rd2; n2_ov += out_valid2;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_counts();
        n_busy = 0; n_done = 0; n_ifm = 0; n_wgt = 0; n_stall = 0;
        n2_busy = 0; n2_done = 0; n2_wgt = 0; n2_acc = 0; n2_psum = 0; n2_ov = 0;
    endtask

    initial begin
        int dir_left;
        bit dir_done;
        clear_counts();
        // start held across the reset-release edge must be dropped
        start = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("no_start_at_release", 64'(n_busy), 64'd0);

        // Run A: no stall, restart attempts while busy; small instance alongside
        clear_counts();
        start = 1'b1; start2 = 1'b1;
        tick();
        start = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            start = (i == 200 || i == 900) ? 1'b1 : 1'b0;
            if (steps.size() == 0 && i > 900) break;
        end
        start = 1'b0;
        repeat (4) tick();
        check("a_busy_cycles", 64'(n_busy), 64'(RUN_BUSY));
        check("a_done_count", 64'(n_done), 64'd1);
        check("a_ifm_rd", 64'(n_ifm), 64'(CO * CI * IFM * IFM));
        check("a_wgt_rd", 64'(n_wgt), 64'(CO * CI * NW));
        check("s_wgt_rd", 64'(n2_wgt), 64'd9);
        check("s_acc_clr", 64'(n2_acc), 64'd1);
        check("s_psum_rd", 64'(n2_psum), 64'd0);
        check("s_out_valid", 64'(n2_ov), 64'd35);
        check("s_busy_cycles", 64'(n2_busy), 64'd52);
        check("s_done_count", 64'(n2_done), 64'd1);

        // Run B: random stall plus one 5-cycle stall at row 2, col 4
        clear_counts();
        dir_left = 0; dir_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (dir_left > 0) begin
                stall = 1'b1; dir_left--;
            end else if (!dir_done && steps.size() > 0 && steps[0].kind == 1 &&
                         steps[0].row == 2 && steps[0].col == 4) begin
                stall = 1'b1; dir_left = 4; dir_done = 1;
            end else begin
                stall = ($urandom_range(0, 9) < 2);
            end
            if (steps.size() == 0) break;
        end
        stall = 1'b0;
        repeat (4) tick();
        check("b_busy_with_stall", 64'(n_busy), 64'(RUN_BUSY + n_stall));
        check("b_done_count", 64'(n_done), 64'd1);
        check("b_ifm_rd", 64'(n_ifm), 64'(CO * CI * IFM * IFM));

        // Run C: reset in the middle of COMPUTE aborts with no done
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (steps.size() > 0 && steps[0].kind == 1 && steps[0].row == 1) break;
        end
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("c_no_done", 64'(n_done), 64'd0);
        check("c_idle_after_abort", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
